mc_test_data_source: RTL and testbench



---
 rtl/mc_test_source_pkg.sv | 16 +
 rtl/mc_wave_gen.sv | 71 +++++++
 rtl/mc_test_data_source.sv | 135 +++++++++++++
 tb/tb_mc_test_data_source.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_test_source_pkg.sv
// Shared types for the synthetic multi-channel test data source.
package mc_test_source_pkg;

  typedef enum logic [1:0] {
    CONSTANT = 2'd0,
    RAMP     = 2'd1,
    TRIANGLE = 2'd2,
    COUNT    = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/mc_wave_gen.sv
// Waveform state (base, direction, sample index); advances once per started burst.
module mc_wave_gen
  import mc_test_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  mode_e                 mode,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] base,
  output logic [DATA_WIDTH-1:0] sample_index
);

  localparam logic [DATA_WIDTH:0] MAX_WIDE = {1'b0, {DATA_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] index_q, index_d;
  logic                  down_q, down_d;
  logic [DATA_WIDTH:0]   sum_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      index_q <= '0;
      down_q  <= 1'b0;
    end else begin
      base_q  <= base_d;
      index_q <= index_d;
      down_q  <= down_d;
    end
  end

  // Wide sum lets the triangle detect saturation without wrapping.
  always_comb begin
    base_d  = base_q;
    index_d = index_q;
    down_d  = down_q;
    sum_c   = {1'b0, base_q} + {1'b0, step};
    if (advance) begin
      case (mode)
        CONSTANT: base_d = step;
        RAMP:     base_d = base_q + step;
        TRIANGLE: begin
          if (!down_q) begin
            if (sum_c >= MAX_WIDE) begin
              base_d = '1;
              down_d = 1'b1;
            end else begin
              base_d = sum_c[DATA_WIDTH-1:0];
            end
          end else begin
            if (base_q <= step) begin
              base_d = '0;
              down_d = 1'b0;
            end else begin
              base_d = base_q - step;
            end
          end
        end
        COUNT:    index_d = index_q + DATA_WIDTH'(1);
        default:  base_d = base_q;
      endcase
    end
  end

  assign base         = base_q;
  assign sample_index = index_q;

endmodule

// File: rtl/mc_test_data_source.sv
// Synthetic multi-channel ADC source: sample timer plus a burst FSM emitting one AXI-stream beat per channel.
module mc_test_data_source
  import mc_test_source_pkg::*;
#(
  parameter int unsigned N_CHANNELS    = 6,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DIVIDER_WIDTH = 16,
  localparam int unsigned DEST_WIDTH   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DIVIDER_WIDTH-1:0] period,
  input  logic [DATA_WIDTH-1:0]    step,
  input  logic [DATA_WIDTH-1:0]    channel_offset,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic [DEST_WIDTH-1:0]    m_tdest,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic                     overrun
);

  logic [DIVIDER_WIDTH-1:0] counter_q, counter_d;
  state_e                   state_q, state_d;
  logic [DEST_WIDTH-1:0]    chan_q, chan_d;
  logic [DATA_WIDTH-1:0]    value_q, value_d;
  logic [DATA_WIDTH-1:0]    offset_q, offset_d;
  mode_e                    mode_q, mode_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     overrun_q, overrun_d;
  logic                     tick_c, advance_c, start_c, hs_c;
  logic [DATA_WIDTH-1:0]    base;
  logic [DATA_WIDTH-1:0]    sample_index;

  mc_wave_gen #(.DATA_WIDTH(DATA_WIDTH)) u_wave_gen (
    .clock        (clock),
    .reset        (reset),
    .advance      (advance_c),
    .mode         (mode_e'(mode)),
    .step         (step),
    .base         (base),
    .sample_index (sample_index)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      state_q   <= IDLE;
      chan_q    <= '0;
      value_q   <= '0;
      offset_q  <= '0;
      mode_q    <= CONSTANT;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      state_q   <= state_d;
      chan_q    <= chan_d;
      value_q   <= value_d;
      offset_q  <= offset_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  // Sample period timer.
  always_comb begin
    counter_d = '0;
    tick_c    = 1'b0;
    if (enable) begin
      if (counter_q == period) begin
        tick_c = 1'b1;
      end else begin
        counter_d = counter_q + DIVIDER_WIDTH'(1);
      end
    end
  end

  // Burst FSM; a tick is only accepted in IDLE or alongside the final handshake.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    value_d   = value_q;
    offset_d  = offset_q;
    mode_d    = mode_q;
    last_d    = last_q;
    overrun_d = 1'b0;
    start_c   = 1'b0;
    hs_c      = valid_q && m_tready;

    case (state_q)
      IDLE: start_c = tick_c;
      SEND: begin
        if (hs_c && last_q) begin
          state_d = IDLE;
          last_d  = 1'b0;
          start_c = tick_c;
        end else begin
          overrun_d = tick_c;
          if (hs_c) begin
            chan_d  = DEST_WIDTH'(32'(chan_q) + 32'd1);
            last_d  = (32'(chan_q) + 32'd1 == N_CHANNELS - 32'd1);
            value_d = (mode_q == COUNT) ? value_q : value_q + offset_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      state_d  = SEND;
      chan_d   = '0;
      last_d   = (N_CHANNELS == 32'd1);
      mode_d   = mode_e'(mode);
      offset_d = channel_offset;
      value_d  = (mode_e'(mode) == COUNT) ? sample_index : base;
    end

    advance_c = start_c;
    valid_d   = (state_d == SEND);
  end

  assign m_tdata  = value_q;
  assign m_tdest  = chan_q;
  assign m_tvalid = valid_q;
  assign m_tlast  = last_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_mc_test_data_source.sv
// Scoreboard bench for mc_test_data_source: directed bursts, monitor pops expected beats on each handshake.
module tb_mc_test_data_source;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  dest;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] period = 16'd0;
  logic [15:0] step = 16'd0;
  logic [15:0] channel_offset = 16'd0;
  logic [15:0] m_tdata;
  logic [2:0]  m_tdest;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        overrun;

  beat_t exp_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    cyc = 0;
  int    last_hs_cyc = 0;
  int    ov_count = 0;

  mc_test_data_source #(
    .N_CHANNELS(6), .DATA_WIDTH(16), .DIVIDER_WIDTH(16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .period         (period),
    .step           (step),
    .channel_offset (channel_offset),
    .m_tdata        (m_tdata),
    .m_tdest        (m_tdest),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a handshake is decided by values stable since the last posedge.
  always @(negedge clock) begin
    beat_t e;
    if (!reset) begin
      if (overrun === 1'b1) ov_count++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {13'd0, m_tdest, m_tdata}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_tdata), 32'(e.data));
          check("beat_dest", 32'(m_tdest), 32'(e.dest));
          check("beat_last", 32'(m_tlast), 32'(e.last));
        end
      end
    end
  end

  task automatic push_burst(input logic [15:0] b, input logic [15:0] off, input bit cnt);
    beat_t e;
    logic [15:0] v;
    v = b;
    for (int c = 0; c < 6; c++) begin
      e.data = v;
      e.dest = 3'(c);
      e.last = (c == 5);
      exp_q.push_back(e);
      if (!cnt) v = v + off;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    exp_q.delete();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("reset_tvalid", 32'(m_tvalid), 32'd0);
    check("reset_tlast", 32'(m_tlast), 32'd0);
    check("reset_tdata", 32'(m_tdata), 32'd0);
    check("reset_tdest", 32'(m_tdest), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_q_le(input int n, input string name);
    int b = 0;
    while (exp_q.size() > n && b < 2000) begin
      @(posedge clock);
      #1;
      b++;
    end
    check(name, 32'(exp_q.size()), 32'(n));
  endtask

  task automatic wait_valid(input string name);
    int b = 0;
    while (m_tvalid !== 1'b1 && b < 200) begin
      @(posedge clock);
      #1;
      b++;
    end
    check(name, 32'(m_tvalid), 32'd1);
  endtask

  initial begin
    int t1, t2, ov0;

    // RAMP: two bursts 10 cycles apart, bases 0x0000 and 0x0100
    do_reset();
    mode = 2'd1; step = 16'h0100; channel_offset = 16'h0010; period = 16'd9; m_tready = 1'b1;
    ov0 = ov_count;
    push_burst(16'h0000, 16'h0010, 1'b0);
    push_burst(16'h0100, 16'h0010, 1'b0);
    enable = 1'b1;
    wait_q_le(11, "ramp_first_beat");
    t1 = last_hs_cyc;
    wait_q_le(5, "ramp_second_burst");
    t2 = last_hs_cyc;
    enable = 1'b0;
    wait_q_le(0, "ramp_drain");
    check("ramp_burst_spacing", 32'(t2 - t1), 32'd10);
    check("ramp_no_overrun", 32'(ov_count - ov0), 32'd0);

    // Backpressure on beat 2 for three cycles
    do_reset();
    ov0 = ov_count;
    push_burst(16'h0000, 16'h0010, 1'b0);
    enable = 1'b1;
    begin
      int b = 0;
      while (!(m_tvalid === 1'b1 && m_tdest === 3'd2) && b < 200) begin
        @(posedge clock);
        #1;
        b++;
      end
    end
    enable = 1'b0;
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(m_tvalid), 32'd1);
      check("bp_hold_data", 32'(m_tdata), 32'h0020);
      check("bp_hold_dest", 32'(m_tdest), 32'd2);
      @(posedge clock);
      #1;
    end
    m_tready = 1'b1;
    wait_q_le(0, "bp_drain");
    check("bp_no_overrun", 32'(ov_count - ov0), 32'd0);

    // Overrun: period 2 with sink stalled for 10 cycles
    do_reset();
    period = 16'd2; m_tready = 1'b0;
    push_burst(16'h0000, 16'h0010, 1'b0);
    push_burst(16'h0100, 16'h0010, 1'b0);
    enable = 1'b1;
    wait_valid("ovr_first_valid");
    ov0 = ov_count;
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    check("ovr_pulses_in_stall", 32'(ov_count - ov0), 32'd3);
    m_tready = 1'b1;
    wait_q_le(6, "ovr_burst1_done");
    @(posedge clock);
    #1;
    wait_valid("ovr_second_valid");
    enable = 1'b0;
    wait_q_le(0, "ovr_drain");

    // TRIANGLE with period 5: each tick lands on the final handshake, bursts run back to back
    do_reset();
    mode = 2'd2; step = 16'h6000; channel_offset = 16'h0000; period = 16'd5; m_tready = 1'b1;
    ov0 = ov_count;
    push_burst(16'h0000, 16'h0, 1'b0);
    push_burst(16'h6000, 16'h0, 1'b0);
    push_burst(16'hC000, 16'h0, 1'b0);
    push_burst(16'hFFFF, 16'h0, 1'b0);
    push_burst(16'h9FFF, 16'h0, 1'b0);
    push_burst(16'h3FFF, 16'h0, 1'b0);
    push_burst(16'h0000, 16'h0, 1'b0);
    push_burst(16'h6000, 16'h0, 1'b0);
    enable = 1'b1;
    wait_q_le(47, "tri_first_beat");
    t1 = last_hs_cyc;
    wait_q_le(5, "tri_last_burst");
    enable = 1'b0;
    wait_q_le(0, "tri_drain");
    t2 = last_hs_cyc;
    check("tri_back_to_back_span", 32'(t2 - t1), 32'd47);
    check("tri_no_overrun", 32'(ov_count - ov0), 32'd0);

    // COUNT with enable dropped mid-burst, then resumed
    do_reset();
    mode = 2'd3; step = 16'h1234; channel_offset = 16'h0010; period = 16'd9;
    push_burst(16'h0000, 16'h0010, 1'b1);
    enable = 1'b1;
    wait_valid("cnt_first_valid");
    @(posedge clock);
    #1;
    enable = 1'b0;
    wait_q_le(0, "cnt_burst1_drain");
    repeat (25) begin
      @(posedge clock);
      #1;
    end
    check("cnt_idle_no_valid", 32'(m_tvalid), 32'd0);
    push_burst(16'h0001, 16'h0010, 1'b1);
    enable = 1'b1;
    wait_valid("cnt_resume_valid");
    enable = 1'b0;
    wait_q_le(0, "cnt_burst2_drain");

    // Reset mid-burst discards the burst; the next burst restarts from base 0
    do_reset();
    mode = 2'd1; step = 16'h0100; channel_offset = 16'h0010; period = 16'd3; m_tready = 1'b0;
    enable = 1'b1;
    wait_valid("rst_mid_valid");
    enable = 1'b0;
    do_reset();
    m_tready = 1'b1;
    push_burst(16'h0000, 16'h0010, 1'b0);
    enable = 1'b1;
    wait_valid("rst_after_valid");
    enable = 1'b0;
    wait_q_le(0, "rst_after_drain");

    repeat (5) @(posedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
